// File: rtl/traffic_light_seq_ctrl.sv
// N-way round-robin traffic light sequencer: INIT -> GREEN -> YELLOW -> ALLRED per approach.
// Optional TLC_SKIP_EN adds a per-way demand input `req` that skips idle approaches.
module traffic_light_seq_ctrl #(
  parameter int NUM_WAYS      = 4,
  parameter int GREEN_CYCLES  = 10,
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 2,
  parameter int CNT_W         = 8,
  localparam int WAY_W        = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
`ifdef TLC_SKIP_EN
  input  logic [NUM_WAYS-1:0] req,
`endif
  output logic [NUM_WAYS-1:0] r,
  output logic [NUM_WAYS-1:0] y,
  output logic [NUM_WAYS-1:0] g,
  output logic [WAY_W-1:0]    way,
  output logic [1:0]          phase
);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_GREEN  = 2'd1;
  localparam logic [1:0] ST_YELLOW = 2'd2;
  localparam logic [1:0] ST_ALLRED = 2'd3;

  localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALLRED_CYCLES - 1);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic [NUM_WAYS-1:0] r_q, r_d, y_q, y_d, g_q, g_d;
  logic [WAY_W-1:0]    next_way;

  assign next_way = (way_q == WAY_W'(NUM_WAYS - 1)) ? '0 : way_q + 1'b1;

`ifdef TLC_SKIP_EN
  logic [WAY_W-1:0] search_base, pick_way;
  logic             any_req;
  int               k;

  // Scan from the base upward; iterating downward lets the lowest offset win.
  always_comb begin
    search_base = (state_q == ST_INIT) ? '0 : next_way;
    pick_way    = search_base;
    k           = 0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      k = (int'(search_base) + i) % NUM_WAYS;
      if (req[k]) pick_way = WAY_W'(k);
    end
  end
  assign any_req = |req;
`endif

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    way_d   = way_q;
    if (!hold) begin
      case (state_q)
        ST_INIT: begin
          if (timer_q == AR_LAST) begin
`ifdef TLC_SKIP_EN
            if (any_req) begin
              state_d = ST_GREEN;
              timer_d = '0;
              way_d   = pick_way;
            end
`else
            state_d = ST_GREEN;
            timer_d = '0;
            way_d   = '0;
`endif
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_GREEN: begin
          if (timer_q == G_LAST) begin
            state_d = ST_YELLOW;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_YELLOW: begin
          if (timer_q == Y_LAST) begin
            state_d = ST_ALLRED;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_ALLRED: begin
          // With no demand the timer parks at its last value until a request appears.
          if (timer_q == AR_LAST) begin
`ifdef TLC_SKIP_EN
            if (any_req) begin
              state_d = ST_GREEN;
              timer_d = '0;
              way_d   = pick_way;
            end
`else
            state_d = ST_GREEN;
            timer_d = '0;
            way_d   = next_way;
`endif
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_INIT;
          timer_d = '0;
          way_d   = '0;
        end
      endcase
    end
  end

  // Lamps are decoded from the next state so they register alongside it.
  always_comb begin
    g_d = '0;
    y_d = '0;
    if (state_d == ST_GREEN)  g_d = {{(NUM_WAYS-1){1'b0}}, 1'b1} << way_d;
    if (state_d == ST_YELLOW) y_d = {{(NUM_WAYS-1){1'b0}}, 1'b1} << way_d;
    r_d = ~(g_d | y_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      timer_q <= '0;
      way_q   <= '0;
      r_q     <= '1;
      y_q     <= '0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      way_q   <= way_d;
      r_q     <= r_d;
      y_q     <= y_d;
      g_q     <= g_d;
    end
  end

  assign r     = r_q;
  assign y     = y_q;
  assign g     = g_q;
  assign way   = way_q;
  assign phase = state_q;

endmodule

// File: tb/tb_traffic_light_seq_ctrl.sv
// Directed bench for traffic_light_seq_ctrl (NUM_WAYS=4, G=10, Y=3, AR=2); TLC_SKIP_EN adds demand tests.
module tb_traffic_light_seq_ctrl;
  localparam int N  = 4;
  localparam int GC = 10;
  localparam int YC = 3;
  localparam int AC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hold = 1'b0;
  logic [3:0] r, y, g;
  logic [1:0] way, phase;
`ifdef TLC_SKIP_EN
  logic [3:0] req = 4'b1111;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  traffic_light_seq_ctrl #(
    .NUM_WAYS(N), .GREEN_CYCLES(GC), .YELLOW_CYCLES(YC),
    .ALLRED_CYCLES(AC), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .hold(hold),
`ifdef TLC_SKIP_EN
    .req(req),
`endif
    .r(r), .y(y), .g(g), .way(way), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in the reset state (INIT, timer 0) with rst low.
  task automatic do_reset();
    rst = 1'b1;
    hold = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hold = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({r, y, g, way, phase} !== {4'hF, 4'h0, 4'h0, 2'd0, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_values: got r=%h y=%h g=%h way=%0d phase=%0d, want r=f y=0 g=0 way=0 phase=0",
               r, y, g, way, phase);
    end
    hold = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_startup();
    do_reset();
    for (int i = 0; i < AC; i++) begin
      n_cmp++;
      if ({r, y, g, phase} !== {4'hF, 4'h0, 4'h0, 2'd0}) begin
        n_bad++;
        $display("FAIL startup_init[%0d]: got r=%h y=%h g=%h phase=%0d, want r=f y=0 g=0 phase=0", i, r, y, g, phase);
      end
      tick();
    end
    for (int i = 0; i < GC; i++) begin
      n_cmp++;
      if ({r, y, g, way, phase} !== {4'hE, 4'h0, 4'h1, 2'd0, 2'd1}) begin
        n_bad++;
        $display("FAIL startup_green0[%0d]: got r=%h y=%h g=%h way=%0d phase=%0d, want r=e y=0 g=1 way=0 phase=1",
                 i, r, y, g, way, phase);
      end
      tick();
    end
    for (int i = 0; i < YC; i++) begin
      n_cmp++;
      if ({r, y, g, way, phase} !== {4'hE, 4'h1, 4'h0, 2'd0, 2'd2}) begin
        n_bad++;
        $display("FAIL startup_yellow0[%0d]: got r=%h y=%h g=%h way=%0d phase=%0d, want r=e y=1 g=0 way=0 phase=2",
                 i, r, y, g, way, phase);
      end
      tick();
    end
    for (int i = 0; i < AC; i++) begin
      n_cmp++;
      if ({r, y, g, way, phase} !== {4'hF, 4'h0, 4'h0, 2'd0, 2'd3}) begin
        n_bad++;
        $display("FAIL startup_allred[%0d]: got r=%h y=%h g=%h way=%0d phase=%0d, want r=f y=0 g=0 way=0 phase=3",
                 i, r, y, g, way, phase);
      end
      tick();
    end
    n_cmp++;
    if ({r, y, g, way, phase} !== {4'hD, 4'h0, 4'h2, 2'd1, 2'd1}) begin
      n_bad++;
      $display("FAIL startup_green1: got r=%h y=%h g=%h way=%0d phase=%0d, want r=d y=0 g=2 way=1 phase=1",
               r, y, g, way, phase);
    end
  endtask

  // Independent phase/way/count model stepped once per clock.
  task automatic test_free_run();
    int p, w, c, len, last_entry, entries;
    logic [1:0] prev_phase;
    logic [3:0] eg, ey, er;
    do_reset();
    p = 0; w = 0; c = 0;
    last_entry = -1; entries = 0;
    prev_phase = 2'd0;
    for (int k = 0; k < 200; k++) begin
      eg = (p == 1) ? (4'b0001 << w) : 4'b0000;
      ey = (p == 2) ? (4'b0001 << w) : 4'b0000;
      er = ~(eg | ey);
      n_cmp++;
      if ({r, y, g, way, phase} !== {er, ey, eg, 2'(w), 2'(p)}) begin
        n_bad++;
        $display("FAIL free_run[%0d]: got r=%h y=%h g=%h way=%0d phase=%0d, want r=%h y=%h g=%h way=%0d phase=%0d",
                 k, r, y, g, way, phase, er, ey, eg, w, p);
      end
      n_cmp++;
      if ((r !== ~(g | y)) || ($countones(g | y) > 1) || ((g & y) !== 4'h0)) begin
        n_bad++;
        $display("FAIL invariant[%0d]: got r=%h y=%h g=%h, want r=~(g|y), one lamp max, g&y=0", k, r, y, g);
      end
      if (phase == 2'd1 && way == 2'd0 && prev_phase != 2'd1) begin
        if (last_entry >= 0) begin
          n_cmp++;
          if (k - last_entry != 60) begin
            n_bad++;
            $display("FAIL rotation_period: got %0d clks between way0 greens, want 60", k - last_entry);
          end
        end
        last_entry = k;
        entries++;
      end
      prev_phase = phase;
      tick();
      len = (p == 1) ? GC : (p == 2) ? YC : AC;
      if (c == len - 1) begin
        c = 0;
        case (p)
          0: begin p = 1; w = 0; end
          1: p = 2;
          2: p = 3;
          default: begin p = 1; w = (w + 1) % N; end
        endcase
      end else begin
        c++;
      end
    end
    n_cmp++;
    if (entries != 4) begin
      n_bad++;
      $display("FAIL way0_green_entries: got %0d, want 4", entries);
    end
  endtask

  task automatic test_hold();
    int cnt, guard;
    do_reset();
    repeat (17) tick();
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (g === 4'h2) cnt++;
      tick();
    end
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (g === 4'h2) cnt++;
      tick();
      n_cmp++;
      if ({r, y, g, way, phase} !== {4'hD, 4'h0, 4'h2, 2'd1, 2'd1}) begin
        n_bad++;
        $display("FAIL hold_stable[%0d]: got r=%h y=%h g=%h way=%0d phase=%0d, want r=d y=0 g=2 way=1 phase=1",
                 i, r, y, g, way, phase);
      end
    end
    hold = 1'b0;
    guard = 0;
    while (g === 4'h2 && guard < 40) begin
      cnt++;
      guard++;
      tick();
    end
    n_cmp++;
    if (cnt != 15) begin
      n_bad++;
      $display("FAIL hold_green_len: got %0d clks, want 15", cnt);
    end
    n_cmp++;
    if ({y, way, phase} !== {4'h2, 2'd1, 2'd2}) begin
      n_bad++;
      $display("FAIL hold_after: got y=%h way=%0d phase=%0d, want y=2 way=1 phase=2", y, way, phase);
    end
  endtask

  task automatic test_reset_midway();
    do_reset();
    repeat (43) tick();
    n_cmp++;
    if ({y, way, phase} !== {4'h4, 2'd2, 2'd2}) begin
      n_bad++;
      $display("FAIL midway_pre: got y=%h way=%0d phase=%0d, want y=4 way=2 phase=2", y, way, phase);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({r, y, g, way, phase} !== {4'hF, 4'h0, 4'h0, 2'd0, 2'd0}) begin
      n_bad++;
      $display("FAIL midway_reset: got r=%h y=%h g=%h way=%0d phase=%0d, want r=f y=0 g=0 way=0 phase=0",
               r, y, g, way, phase);
    end
    tick();
    n_cmp++;
    if ({r, phase} !== {4'hF, 2'd0}) begin
      n_bad++;
      $display("FAIL midway_init: got r=%h phase=%0d, want r=f phase=0", r, phase);
    end
    tick();
    n_cmp++;
    if ({g, way, phase} !== {4'h1, 2'd0, 2'd1}) begin
      n_bad++;
      $display("FAIL midway_green0: got g=%h way=%0d phase=%0d, want g=1 way=0 phase=1", g, way, phase);
    end
  endtask

  task automatic test_rst_over_hold();
    do_reset();
    repeat (5) tick();
    hold = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({r, g, way, phase} !== {4'hF, 4'h0, 2'd0, 2'd0}) begin
      n_bad++;
      $display("FAIL rst_over_hold: got r=%h g=%h way=%0d phase=%0d, want r=f g=0 way=0 phase=0", r, g, way, phase);
    end
    repeat (4) tick();
    n_cmp++;
    if ({r, phase} !== {4'hF, 2'd0}) begin
      n_bad++;
      $display("FAIL hold_in_init: got r=%h phase=%0d, want r=f phase=0", r, phase);
    end
    hold = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({g, phase} !== {4'h1, 2'd1}) begin
      n_bad++;
      $display("FAIL init_after_hold: got g=%h phase=%0d, want g=1 phase=1", g, phase);
    end
  endtask

`ifdef TLC_SKIP_EN
  task automatic test_skip();
    req = 4'b0001;
    do_reset();
    repeat (2) tick();
    req = 4'b0100;
    repeat (GC + YC + AC) tick();
    n_cmp++;
    if ({g, way, phase} !== {4'h4, 2'd2, 2'd1}) begin
      n_bad++;
      $display("FAIL skip_to_way2: got g=%h way=%0d phase=%0d, want g=4 way=2 phase=1", g, way, phase);
    end
    req = 4'b0000;
    repeat (GC + YC + AC + 5) tick();
    n_cmp++;
    if ({r, way, phase} !== {4'hF, 2'd2, 2'd3}) begin
      n_bad++;
      $display("FAIL skip_park: got r=%h way=%0d phase=%0d, want r=f way=2 phase=3", r, way, phase);
    end
    req = 4'b0001;
    tick();
    n_cmp++;
    if ({g, way, phase} !== {4'h1, 2'd0, 2'd1}) begin
      n_bad++;
      $display("FAIL skip_resume: got g=%h way=%0d phase=%0d, want g=1 way=0 phase=1", g, way, phase);
    end
    req = 4'b1111;
  endtask
`endif

  initial begin
    test_reset();
    test_startup();
    test_free_run();
    test_hold();
    test_reset_midway();
    test_rst_over_hold();
`ifdef TLC_SKIP_EN
    test_skip();
    test_free_run();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
